rv_decode_iq: RTL
=================

Name: rv_decode_iq

Overview:
- Next-generation decode stage: a parametrised instruction queue (IQ) between fetch and execute with valid/ready handshake toward fetch.
- Resolves load-use hazards internally by inserting bubbles, tracking up to HAZARD_DEPTH in-flight loads instead of flagging one.
- Produces X-stage decoded fields plus a single format-selected immediate.

Parameters:
IQ_DEPTH, 2, queue entries (power of two, >=2)
HAZARD_DEPTH, 1, number of issued loads tracked for load-use stalls (1..4)
RESET_PC, 32'h0, x_pc_o value after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active high
f_ir_i  in  32  fetched instruction
f_pc_i  in  32  its PC
f_valid_i  in  1  fetch offers an instruction
f_ready_o  out  1  queue can accept (registered: !full)
d_stall_i  in  1  freeze decode/X registers and hazard tracker
d_kill_i  in  1  flush queue and invalidate issue
rf_rs1_o  out  5  regfile read address 1 for the instruction in X next cycle
rf_rs2_o  out  5  regfile read address 2, same rule
x_valid_o  out  1  X-stage instruction valid
x_pc_o  out  32  X-stage PC
x_rs1_o, x_rs2_o, x_rd_o  out  5 each  register fields of X instruction
x_opcode_o  out  5  ir[6:2]
x_fun_o  out  3  FUNC_ADD for JAL/JALR/LUI/AUIPC, else ir[14:12]
x_shifter_sign_o  out  1  ir[30]
x_shamt_o  out  5  ir[24:20]
x_imm_o  out  32  immediate selected by opcode format (I/S/B/U/J; 0 for R-type)

Behaviour:
- Reset (async): queue empty, f_ready_o=1, x_valid_o=0, x_pc_o=RESET_PC, X instruction register=32'h00000013 (NOP), hazard tracker all invalid.
- Push: f_valid_i && f_ready_o && !d_kill_i at an edge writes {ir,pc} at tail. f_ready_o = count<IQ_DEPTH, from registered count; no push when full even if a pop occurs in the same cycle.
- Head visible combinationally from the cycle after the push. Minimum latency accept->x_valid_o=1 is 2 edges.
- Issue at an edge when !d_stall_i: if head valid and no hazard, pop head into X; x_valid_o=1. Otherwise (empty or hazard) load NOP bubble with x_valid_o=0, x_pc_o held.
- Hazard: head is a consumer of rd of any valid tracker entry with rd!=0. rs1 used by all opcodes except LUI/AUIPC/JAL. rs2 used by OP, STORE, BRANCH only. Tracker is a shift register; entry 0 = instruction now in X.
- Tracker shift on each non-stalled edge: shift in {opcode==OPC_LOAD && issued, rd}; bubbles shift in invalid.
- d_stall_i=1: X regs, queue head and tracker hold. Pushes are still allowed.
- rf_rs*_o: if d_stall_i, from current X instruction; else from head (current X fields when queue empty).
- d_kill_i at an edge: count->0, x_valid_o->0 (kill wins over stall and push); tracker shifts in invalid, older entries keep shifting.
- Pointers wrap modulo IQ_DEPTH; count is $clog2(IQ_DEPTH)+1 bits.
- Reset mid-operation discards all entries immediately.

Optional Feature:
RV_DECODE_ILLEGAL_EN
- Defined: adds output x_illegal_o (1 bit), registered with X. High when x_valid_o and opcode is outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP} or ir[1:0]!=2'b11. Reset 0.
- Undefined: port absent; no checking.

Decomposition:
- Shared package/defs file: OPC_* opcode constants, FUNC_ADD, NOP encoding, immediate-format enum.
- Sub-module rv_iq_fifo: parametrised synchronous FIFO with flush, count, combinational head.
- Decode, immediate selection and hazard logic stay in top.

Test Plan:
- Reset, push ADDI x1,x0,5 (0x00500093) at PC 0x100 -> x_valid_o=1 two edges later, x_pc_o=0x100, x_imm_o=5, x_fun_o=0.
- LW x2,0(x1) then ADD x3,x2,x2, HAZARD_DEPTH=1 -> one bubble (x_valid_o=0 one cycle), then ADD issues. Same with rd=x0 -> no bubble.
- IQ_DEPTH=2, fetch valid every cycle, d_stall_i held 4 cycles -> f_ready_o=0 after 2 pushes. No entry lost or duplicated; PCs exit in order.
- d_kill_i with 2 queued entries -> next edge x_valid_o=0, queue empty, f_ready_o=1; the push offered during the kill cycle is discarded.
- JAL x1,+8 -> x_fun_o=FUNC_ADD, x_imm_o=8. BEQ with offset -4 -> x_imm_o=32'hFFFFFFFC.
- rst_i asserted mid-stream -> outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/rv_decode_iq_pkg.sv
// rv_decode_iq_pkg: opcode constants, NOP encoding and decode helpers shared by rv_decode_iq.
package rv_decode_iq_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [2:0]  FUNC_ADD = 3'b000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [4:0] opc);
        return (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
               (opc == OPC_JAL) ? IMM_J :
               (opc == OPC_BRANCH) ? IMM_B :
               (opc == OPC_STORE) ? IMM_S :
               (opc == OPC_LOAD || opc == OPC_OP_IMM || opc == OPC_JALR) ? IMM_I : IMM_R;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:7] ir, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{ir[31]}}, ir[31:20]};
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   return {ir[31:12], 12'h000};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [4:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] opc);
        return opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH;
    endfunction

    function automatic logic is_legal(input logic [6:0] ir);
        return ir[1:0] == 2'b11 && (ir[6:2] inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP});
    endfunction

endpackage

// File: rtl/rv_iq_fifo.sv
// rv_iq_fifo: synchronous FIFO with flush, occupancy count and combinational head.
module rv_iq_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // full blocks a push even when a pop frees a slot on the same edge
    assign do_push = push && count != (AW+1)'(DEPTH);
    assign do_pop  = pop && count != '0;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/rv_decode_iq.sv
// rv_decode_iq: fetch-side instruction queue feeding decode/X with load-use bubbling.
// Optional x_illegal_o output enabled by RV_DECODE_ILLEGAL_EN.
module rv_decode_iq
    import rv_decode_iq_pkg::*;
#(
    parameter int          IQ_DEPTH     = 2,
    parameter int          HAZARD_DEPTH = 1,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    output logic        f_ready_o,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        x_valid_o,
    output logic [31:0] x_pc_o,
    output logic [4:0]  x_rs1_o,
    output logic [4:0]  x_rs2_o,
    output logic [4:0]  x_rd_o,
    output logic [4:0]  x_opcode_o,
    output logic [2:0]  x_fun_o,
    output logic        x_shifter_sign_o,
    output logic [4:0]  x_shamt_o,
`ifdef RV_DECODE_ILLEGAL_EN
    output logic        x_illegal_o,
`endif
    output logic [31:0] x_imm_o
);
    localparam int CW = $clog2(IQ_DEPTH) + 1;

    logic [CW-1:0]           count;
    logic [63:0]             head;
    logic [31:0]             head_ir, head_pc, x_ir;
    logic                    head_valid, push, issue, hazard, use_x;
    logic [HAZARD_DEPTH-1:0] trk_v;
    logic [4:0]              trk_rd [HAZARD_DEPTH];

    assign f_ready_o  = count < CW'(IQ_DEPTH);
    assign head_valid = count != '0;
    assign push       = f_valid_i && f_ready_o && !d_kill_i;
    assign head_ir    = head[63:32];
    assign head_pc    = head[31:0];

    rv_iq_fifo #(.DEPTH(IQ_DEPTH), .W(64)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (issue),
        .flush (d_kill_i),
        .din   ({f_ir_i, f_pc_i}),
        .head  (head),
        .count (count)
    );

    // head waits while any tracked load still owes a register it reads
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++)
            if (trk_v[i] && trk_rd[i] != 5'd0 &&
                ((uses_rs1(head_ir[6:2]) && head_ir[19:15] == trk_rd[i]) ||
                 (uses_rs2(head_ir[6:2]) && head_ir[24:20] == trk_rd[i])))
                hazard = 1'b1;
    end

    assign issue = head_valid && !hazard && !d_stall_i && !d_kill_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_valid_o <= 1'b0;
            x_pc_o    <= RESET_PC;
            x_ir      <= NOP;
            trk_v     <= '0;
            trk_rd    <= '{default: '0};
`ifdef RV_DECODE_ILLEGAL_EN
            x_illegal_o <= 1'b0;
`endif
        end else if (d_kill_i || !d_stall_i) begin
            x_valid_o <= issue;
            x_ir      <= issue ? head_ir : NOP;
            if (issue) x_pc_o <= head_pc;
            trk_v[0]  <= issue && head_ir[6:2] == OPC_LOAD;
            trk_rd[0] <= head_ir[11:7];
            for (int i = 1; i < HAZARD_DEPTH; i++) begin
                trk_v[i]  <= trk_v[i-1];
                trk_rd[i] <= trk_rd[i-1];
            end
`ifdef RV_DECODE_ILLEGAL_EN
            x_illegal_o <= issue && !is_legal(head_ir[6:0]);
`endif
        end
    end

`ifndef RV_DECODE_ILLEGAL_EN
    logic unused_ir_lsb;
    assign unused_ir_lsb = ^x_ir[1:0];
`endif

    assign use_x            = d_stall_i || !head_valid;
    assign rf_rs1_o         = use_x ? x_ir[19:15] : head_ir[19:15];
    assign rf_rs2_o         = use_x ? x_ir[24:20] : head_ir[24:20];
    assign x_rs1_o          = x_ir[19:15];
    assign x_rs2_o          = x_ir[24:20];
    assign x_rd_o           = x_ir[11:7];
    assign x_opcode_o       = x_ir[6:2];
    assign x_fun_o          = (x_ir[6:2] inside {OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC}) ? FUNC_ADD : x_ir[14:12];
    assign x_shifter_sign_o = x_ir[30];
    assign x_shamt_o        = x_ir[24:20];
    assign x_imm_o          = imm_gen(x_ir[31:7], imm_fmt(x_ir[6:2]));

endmodule
